// File: rtl/bus_owner_arbiter_if.sv
// Shared-bus request/drive bundle between the requesters and the bus owner arbiter.
interface bus_owner_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic                  bus_oe;
    logic [WIDTH-1:0]      bus_out;
    logic [NREQ-1:0]       gnt;
    logic                  busy;

    modport master (output req, output wdata, input bus_oe, input bus_out, input gnt, input busy);
    modport slave  (input req, input wdata, output bus_oe, output bus_out, output gnt, output busy);
endinterface

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus: hold limit per grant and a
// one-cycle turnaround between owners so two drivers never overlap.
module bus_owner_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    bus_owner_arbiter_if.slave bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} state_t;

    state_t          r_state, w_state_nxt;
    logic [IDXW-1:0] r_owner, w_owner_nxt;
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]      r_hold_cnt, w_hold_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDXW-1:0] w_win;
    logic            w_any;
    logic            w_release;

    // First requester at or after p, wrapping around.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDXW-1:0] p);
        logic            found;
        logic [IDXW-1:0] win;
        int              idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[IDXW'(idx)]) begin
                found = 1'b1;
                win   = IDXW'(idx);
            end
        end
        return win;
    endfunction

    assign w_any     = |bus.req;
    assign w_win     = rr_pick(bus.req, r_ptr);
    assign w_release = !bus.req[r_owner] || (r_hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            ST_IDLE, ST_TURN: begin
                if (w_any) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_win;
                    w_hold_nxt  = 8'd1;
                    w_gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                    w_gnt_nxt   = '0;
                end
            end
            ST_OWN: begin
                // Non-owner requests are ignored here; only a drop or the hold limit ends the grant.
                if (w_release) begin
                    w_state_nxt = ST_TURN;
                    w_hold_nxt  = '0;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = (r_owner == IDXW'(NREQ-1)) ? '0 : r_owner + 1'b1;
                end else begin
                    w_hold_nxt  = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign bus.bus_oe  = (r_state == ST_OWN);
    assign bus.bus_out = (r_state == ST_OWN) ? bus.wdata[r_owner*WIDTH +: WIDTH] : '0;
    assign bus.gnt     = r_gnt;
    assign bus.busy    = (r_state != ST_IDLE);
endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Directed bench for bus_owner_arbiter: a cycle-level ownership model checked every
// cycle, plus literal expectations for the reset, grant, round-robin and hold cases.
module tb_bus_owner_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic reset;
    bus_owner_arbiter_if #(.NREQ(N), .WIDTH(W)) bif ();

    bus_owner_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the bus this cycle (-1 none), whether this is a turnaround cycle,
    // how long the owner has held it, and where the next search starts.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit m_turn  = 0;
    bit started = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0; m_turn = 0;
        end else if (m_owner >= 0) begin
            if (!bif.req[m_owner] || m_cnt == MH) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_turn  = 1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_turn = 0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && bif.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            if (m_owner >= 0) m_cnt = 1;
        end
    end

    logic          prev_oe;
    logic [N-1:0]  prev_gnt;
    initial prev_oe = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            logic [N-1:0] eg;
            logic [W-1:0] eo;
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            eo = (m_owner >= 0) ? bif.wdata[m_owner*W +: W] : '0;
            chk("model_gnt",     32'(bif.gnt),     32'(eg));
            chk("model_bus_oe",  32'(bif.bus_oe),  32'(m_owner >= 0));
            chk("model_bus_out", 32'(bif.bus_out), 32'(eo));
            chk("model_busy",    32'(bif.busy),    32'(m_owner >= 0 || m_turn));
            chk("onehot0_gnt",   32'($onehot0(bif.gnt)), 32'd1);
            if (prev_oe && bif.bus_oe)
                chk("no_direct_handoff", 32'(bif.gnt), 32'(prev_gnt));
            prev_oe  = bif.bus_oe;
            prev_gnt = bif.gnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        bif.req  = '0;
        for (int i = 0; i < N; i++) bif.wdata[i*W +: W] = 16'h1100 * 16'(i + 1);
        bif.wdata[2*W +: W] = 16'd13333;
        step(); step();
        reset = 1'b0;

        // Reset release with no requests
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt",  32'(bif.gnt),    32'd0);
            chk("rst_oe",   32'(bif.bus_oe), 32'd0);
            chk("rst_busy", 32'(bif.busy),   32'd0);
        end

        // Single grant, combinational data path, turnaround, idle
        bif.req = 4'b0100;
        step();
        chk("sg_gnt", 32'(bif.gnt),     32'h4);
        chk("sg_oe",  32'(bif.bus_oe),  32'd1);
        chk("sg_out", 32'(bif.bus_out), 32'd13333);
        bif.wdata[2*W +: W] = 16'h0ABC;
        #1;
        chk("sg_out_comb", 32'(bif.bus_out), 32'h0ABC);
        bif.wdata[2*W +: W] = 16'd13333;
        bif.req = 4'b0000;
        step();
        chk("sg_turn_oe",   32'(bif.bus_oe),  32'd0);
        chk("sg_turn_busy", 32'(bif.busy),    32'd1);
        chk("sg_turn_out",  32'(bif.bus_out), 32'd0);
        step();
        chk("sg_idle_busy", 32'(bif.busy), 32'd0);

        // Round robin with all requesting: 8 owned cycles then one turnaround, owners 0,1,2,3,0
        do_reset();
        bif.req = 4'b1111;
        for (int i = 0; i < 45; i++) begin
            logic [N-1:0] eg;
            step();
            eg = ((i % 9) == 8) ? 4'b0000 : (4'b0001 << ((i / 9) % 4));
            chk("rr_gnt", 32'(bif.gnt),    32'(eg));
            chk("rr_oe",  32'(bif.bus_oe), 32'(eg != 0));
        end

        // Single requester hits the hold limit repeatedly
        do_reset();
        bif.req = 4'b0001;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("mh_oe", 32'(bif.bus_oe), 32'((i % 9) < 8));
            if ((i % 9) < 8) chk("mh_gnt", 32'(bif.gnt), 32'h1);
        end

        // Owner drops early; next round-robin candidate follows after one turnaround
        do_reset();
        bif.req = 4'b1010;
        step();
        chk("ed_gnt1", 32'(bif.gnt), 32'h2);
        step();
        bif.req = 4'b1000;
        step();
        chk("ed_turn_oe", 32'(bif.bus_oe), 32'd0);
        step();
        chk("ed_gnt3", 32'(bif.gnt), 32'h8);

        // Reset in owner cycle 3; non-owner request ignored while owning
        do_reset();
        bif.req = 4'b0010;
        step();
        step();
        bif.req = 4'b0011;
        step();
        chk("mr_gnt_c3", 32'(bif.gnt), 32'h2);
        reset = 1'b1;
        step();
        chk("mr_gnt",  32'(bif.gnt),    32'd0);
        chk("mr_oe",   32'(bif.bus_oe), 32'd0);
        chk("mr_busy", 32'(bif.busy),   32'd0);
        reset = 1'b0;
        bif.req = 4'b1110;
        step();
        chk("mr_restart_gnt", 32'(bif.gnt), 32'h2);

        bif.req = 4'b0000;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
